// File: rtl/fc_mac_seq_pkg.sv
// ============================================================================
// Module : fc_pkg
// Brief  : Shared types and constants for the fully-connected MAC sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fc_pkg;

   localparam int DATA_W      = 8;
   localparam int MAC_CAP_LAT = 3;
   localparam int DRAIN_CYC   = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/fc_mac_seq_if.sv
// ============================================================================
// Module : fc_mac_seq_if
// Brief  : Memory-read and MAC-control bundle between the sequencer and the
//          image/weight memories plus the MAC bank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface fc_mac_seq_if
   import fc_pkg::*;
#(
   parameter int N_IN  = 784,
   parameter int N_OUT = 64,
   parameter int N_PAR = 8
);
   localparam int N_GRP = N_OUT / N_PAR;
   localparam int IW    = $clog2(N_IN);
   localparam int WW    = $clog2(N_IN * N_GRP);
   localparam int GW    = (N_GRP > 1) ? $clog2(N_GRP) : 1;

   logic [IW-1:0]           img_addr_o;
   logic [DATA_W-1:0]       img_rdata_i;
   logic [WW-1:0]           w_addr_o;
   logic [N_PAR*DATA_W-1:0] w_rdata_i;
   logic                    mem_re_o;
   logic                    mac_en_o;
   logic                    mac_valid_o;
   logic                    mac_clear_o;
   logic [DATA_W-1:0]       image_data_o;
   logic [N_PAR*DATA_W-1:0] weight_data_o;
   logic                    res_strobe_o;
   logic [GW-1:0]           res_group_o;

   modport master (
      output img_addr_o, w_addr_o, mem_re_o,
      output mac_en_o, mac_valid_o, mac_clear_o,
      output image_data_o, weight_data_o,
      output res_strobe_o, res_group_o,
      input  img_rdata_i, w_rdata_i
   );

   modport slave (
      input  img_addr_o, w_addr_o, mem_re_o,
      input  mac_en_o, mac_valid_o, mac_clear_o,
      input  image_data_o, weight_data_o,
      input  res_strobe_o, res_group_o,
      output img_rdata_i, w_rdata_i
   );

endinterface

`default_nettype wire

// File: rtl/fc_mac_seq_addr_gen.sv
// ============================================================================
// Module : fc_addr_gen
// Brief  : k/g counters and running weight base; registered read addresses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fc_addr_gen #(
   parameter int N_IN  = 784,
   parameter int N_GRP = 8
)(
   input  wire logic                                              clk_i,
   input  wire logic                                              rstn_i,
   input  wire logic                                              i_init,
   input  wire logic                                              i_step,
   input  wire logic                                              i_next_grp,
   output logic [$clog2(N_IN)-1:0]                                o_img_addr,
   output logic [$clog2(N_IN*N_GRP)-1:0]                          o_w_addr,
   output logic [((N_GRP > 1) ? $clog2(N_GRP) : 1)-1:0]           o_grp,
   output logic                                                   o_last_k,
   output logic                                                   o_last_g
);
   localparam int IW = $clog2(N_IN);
   localparam int WW = $clog2(N_IN * N_GRP);
   localparam int GW = (N_GRP > 1) ? $clog2(N_GRP) : 1;

   localparam logic [IW-1:0] c_K_LAST = IW'(N_IN - 1);
   localparam logic [GW-1:0] c_G_LAST = GW'(N_GRP - 1);
   localparam logic [WW-1:0] c_N_IN   = WW'(N_IN);

   logic [IW-1:0] r_k;
   logic [GW-1:0] r_g;
   logic [WW-1:0] r_base;
   logic [WW-1:0] r_w_addr;

   // w_addr runs alongside k, so it lands on base+N_IN after the last k;
   // the group step reloads it from the base to keep both in lock-step.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_k      <= '0;
         r_g      <= '0;
         r_base   <= '0;
         r_w_addr <= '0;
      end else if (i_init) begin
         r_k      <= '0;
         r_g      <= '0;
         r_base   <= '0;
         r_w_addr <= '0;
      end else begin
         if (i_step) begin
            r_k      <= o_last_k ? '0 : r_k + IW'(1);
            r_w_addr <= r_w_addr + WW'(1);
         end
         if (i_next_grp) begin
            r_g      <= r_g + GW'(1);
            r_base   <= r_base + c_N_IN;
            r_w_addr <= r_base + c_N_IN;
         end
      end
   end

   assign o_img_addr = r_k;
   assign o_w_addr   = r_w_addr;
   assign o_grp      = r_g;
   assign o_last_k   = (r_k == c_K_LAST);
   assign o_last_g   = (r_g == c_G_LAST);

endmodule

`default_nettype wire

// File: rtl/fc_mac_seq.sv
// ============================================================================
// Module : fc_mac_seq
// Brief  : Streams activations and weights into a bank of MAC lanes for one
//          fully-connected layer and flags when each group's results are valid.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fc_mac_seq
   import fc_pkg::*;
#(
   parameter int N_IN  = 784,
   parameter int N_OUT = 64,
   parameter int N_PAR = 8
)(
   input  wire logic    clk_i,
   input  wire logic    rstn_i,
   input  wire logic    start_i,
   output logic         busy_o,
   output logic         done_o,
   fc_mac_seq_if.master bus
);
   localparam int N_GRP = N_OUT / N_PAR;
   localparam int IW    = $clog2(N_IN);
   localparam int WW    = $clog2(N_IN * N_GRP);
   localparam int GW    = (N_GRP > 1) ? $clog2(N_GRP) : 1;
   localparam int DCW   = $clog2(DRAIN_CYC);

   localparam logic [DCW-1:0] c_DRAIN_LAST = DCW'(DRAIN_CYC - 1);

   state_t                 r_state;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_mem_re;
   logic                   r_mac_clear;
   logic                   r_mac_en;
   logic                   r_mac_valid;
   logic [MAC_CAP_LAT-1:0] r_cap_dly;
   logic [GW-1:0]          r_res_group;
   logic [DCW-1:0]         r_drain_cnt;

   logic [IW-1:0]          w_img_addr;
   logic [WW-1:0]          w_w_addr;
   logic [GW-1:0]          w_grp;
   logic                   w_last_k;
   logic                   w_last_g;
   logic                   w_init;
   logic                   w_step;
   logic                   w_drain_end;
   logic                   w_next_grp;

   assign w_init      = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_step      = (r_state == S_RUN);
   assign w_drain_end = (r_state == S_DRAIN) && (r_drain_cnt == c_DRAIN_LAST);
   assign w_next_grp  = w_drain_end && !w_last_g;

   fc_addr_gen #(
      .N_IN  (N_IN),
      .N_GRP (N_GRP)
   ) u_addr_gen (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .i_init     (w_init),
      .i_step     (w_step),
      .i_next_grp (w_next_grp),
      .o_img_addr (w_img_addr),
      .o_w_addr   (w_w_addr),
      .o_grp      (w_grp),
      .o_last_k   (w_last_k),
      .o_last_g   (w_last_g)
   );

   // Outputs are set on the transition into the state that owns them.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_mem_re    <= 1'b0;
         r_mac_clear <= 1'b0;
         r_drain_cnt <= '0;
      end else begin
         r_done      <= 1'b0;
         r_mem_re    <= 1'b0;
         r_mac_clear <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // The done cycle still reads as IDLE; a start there is dropped.
               if (start_i && !r_done) begin
                  r_state     <= S_CLEAR;
                  r_busy      <= 1'b1;
                  r_mac_clear <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_state  <= S_RUN;
               r_mem_re <= 1'b1;
            end
            S_RUN: begin
               if (w_last_k) begin
                  r_state     <= S_DRAIN;
                  r_drain_cnt <= '0;
               end else begin
                  r_mem_re <= 1'b1;
               end
            end
            S_DRAIN: begin
               r_drain_cnt <= r_drain_cnt + DCW'(1);
               if (w_drain_end) begin
                  r_state     <= w_last_g ? S_DONE : S_CLEAR;
                  r_mac_clear <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // MAC pipeline: enable trails the read by the memory latency, capture
   // follows the final enable, and the strobe trails capture by the MAC latency.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_mac_en    <= 1'b0;
         r_mac_valid <= 1'b0;
         r_cap_dly   <= '0;
         r_res_group <= '0;
      end else begin
         r_mac_en    <= r_mem_re;
         r_mac_valid <= r_mac_en && !r_mem_re;
         r_cap_dly   <= {r_cap_dly[MAC_CAP_LAT-2:0], r_mac_valid};
         r_res_group <= r_cap_dly[MAC_CAP_LAT-2] ? w_grp : '0;
      end
   end

   assign busy_o            = r_busy;
   assign done_o            = r_done;
   assign bus.img_addr_o    = w_img_addr;
   assign bus.w_addr_o      = w_w_addr;
   assign bus.mem_re_o      = r_mem_re;
   assign bus.mac_en_o      = r_mac_en;
   assign bus.mac_valid_o   = r_mac_valid;
   assign bus.mac_clear_o   = r_mac_clear;
   assign bus.res_strobe_o  = r_cap_dly[MAC_CAP_LAT-1];
   assign bus.res_group_o   = r_res_group;
   assign bus.image_data_o  = r_mac_en ? bus.img_rdata_i : '0;
   assign bus.weight_data_o = r_mac_en ? bus.w_rdata_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_fc_mac_seq.sv
// ============================================================================
// Module : tb_fc_mac_seq
// Brief  : Scoreboard bench for fc_mac_seq with N_IN=4, N_OUT=4, N_PAR=2.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fc_mac_seq;
   import fc_pkg::*;

   localparam int N_IN  = 4;
   localparam int N_OUT = 4;
   localparam int N_PAR = 2;
   localparam int N_GRP = N_OUT / N_PAR;
   localparam int PER   = N_IN + 5;

   logic clk   = 1'b0;
   logic rstn  = 1'b1;
   logic start = 1'b0;
   logic busy;
   logic done;

   fc_mac_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .N_PAR(N_PAR)) bus ();

   fc_mac_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .N_PAR(N_PAR)) dut (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .start_i (start),
      .busy_o  (busy),
      .done_o  (done),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous memories, answering every cycle whether read or not.
   bit mode_const = 1'b1;
   always @(posedge clk) begin
      if (mode_const) begin
         bus.img_rdata_i <= 8'h7F;
         bus.w_rdata_i   <= 16'h0180;
      end else begin
         bus.img_rdata_i <= {4'h5, 2'b00, bus.img_addr_o};
         bus.w_rdata_i   <= {5'b01000, bus.w_addr_o, 5'b10100, bus.w_addr_o};
      end
   end

   typedef struct {
      int cyc;
      int grp;
   } ev_t;

   ev_t q_strobe[$];
   ev_t q_done[$];
   int  run_s = -1;
   int  n_cmp = 0;
   int  n_err = 0;

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, req);
      end
   endtask

   task automatic expect_run(input int s);
      run_s = s;
      for (int g = 0; g < N_GRP; g++)
         q_strobe.push_back('{s + 1 + (g + 1) * PER, g});
      q_done.push_back('{s + 1 + N_GRP * PER + 1, 0});
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input int c, input bit accepted);
      goto(c);
      start = 1'b1;
      if (accepted) expect_run(c);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Reference schedule, relative to the cycle in which start was sampled.
   int  m_t, m_g, m_u, m_k, m_wa;
   int  e_ctl, e_img, e_w, e_ia, e_wa;
   bit  m_chk_addr;
   ev_t m_ev;

   always @(negedge clk) begin
      e_ctl = 0; e_img = 0; e_w = 0; e_ia = 0; e_wa = 0;
      m_chk_addr = 1'b1;
      if (run_s >= 0) begin
         m_t = cyc - run_s;
         if (m_t >= 1 && m_t <= N_GRP * PER + 1) begin
            e_ctl |= 16;
            if (m_t == N_GRP * PER + 1) begin
               e_ctl |= 1;
               m_chk_addr = 1'b0;
            end else begin
               m_g = (m_t - 1) / PER;
               m_u = (m_t - 1) % PER;
               if (m_u == 0) e_ctl |= 1;
               if (m_u >= 1 && m_u <= N_IN) begin
                  e_ctl |= 8;
                  e_ia = m_u - 1;
                  e_wa = m_g * N_IN + m_u - 1;
               end else begin
                  m_chk_addr = 1'b0;
               end
               if (m_u >= 2 && m_u <= N_IN + 1) begin
                  e_ctl |= 4;
                  m_k  = m_u - 2;
                  m_wa = m_g * N_IN + m_k;
                  if (mode_const) begin
                     e_img = 'h7F;
                     e_w   = 'h0180;
                  end else begin
                     e_img = 'h50 + m_k;
                     e_w   = (('h40 + m_wa) << 8) | ('hA0 + m_wa);
                  end
               end
               if (m_u == N_IN + 2) e_ctl |= 2;
            end
         end
      end
      chk("ctl{busy,re,en,valid,clear}",
          int'({busy, bus.mem_re_o, bus.mac_en_o, bus.mac_valid_o, bus.mac_clear_o}), e_ctl);
      chk("image_data", int'(bus.image_data_o), e_img);
      chk("weight_data", int'(bus.weight_data_o), e_w);
      if (m_chk_addr) begin
         chk("img_addr", int'(bus.img_addr_o), e_ia);
         chk("w_addr", int'(bus.w_addr_o), e_wa);
      end

      if (bus.res_strobe_o) begin
         if (q_strobe.size() == 0) begin
            chk("strobe_unexpected", int'(bus.res_strobe_o), 0);
         end else begin
            m_ev = q_strobe.pop_front();
            chk("strobe_cycle", cyc, m_ev.cyc);
            chk("strobe_group", int'(bus.res_group_o), m_ev.grp);
         end
      end
      if (done) begin
         if (q_done.size() == 0) begin
            chk("done_unexpected", int'(done), 0);
         end else begin
            m_ev = q_done.pop_front();
            chk("done_cycle", cyc, m_ev.cyc);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1);
   end

   int b;

   initial begin
      #2 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;

      // Constant memory data, stray start mid-run, start on done, back-to-back.
      mode_const = 1'b1;
      b = cyc;
      pulse_start(b + 0, 1'b1);
      pulse_start(b + 5, 1'b0);
      pulse_start(b + 20, 1'b0);
      pulse_start(b + 21, 1'b1);
      goto(b + 46);

      // Address-dependent data, reset mid-run, then a clean rerun.
      mode_const = 1'b0;
      goto(b + 48);
      b = cyc;
      pulse_start(b + 0, 1'b1);
      goto(b + 8);
      rstn  = 1'b0;
      run_s = -1;
      q_strobe.delete();
      q_done.delete();
      goto(b + 9);
      rstn = 1'b1;
      pulse_start(b + 12, 1'b1);
      goto(b + 12 + 26);

      chk("strobe_queue_left", q_strobe.size(), 0);
      chk("done_queue_left", q_done.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
